inverter_arbiter: RTL and testbench

INVERTER_ARBITER -- requirements
Module: inverter_arbiter

---
 rtl/inverter_arbiter.sv | 108 ++++++++++
 tb/tb_inverter_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inverter_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : inverter_arbiter
// Brief   : Round-robin N:1 arbiter feeding one output register that holds the
//           bitwise inverse of the granted word together with its source index.
// Revision: 1.0
// ============================================================================
module inverter_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_WIDTH-1:0]           out_id,
    input  logic                          out_ready
);

    localparam logic [ID_WIDTH-1:0] c_LAST_IDX = ID_WIDTH'(NUM_REQ - 1);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;

    logic                  w_can_load;
    logic                  w_found;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic [ID_WIDTH-1:0]   w_sel;
    logic [ID_WIDTH-1:0]   w_idx;
    logic [DATA_WIDTH-1:0] w_word;

    // The register may take a new word when empty or when it is being drained.
    assign w_can_load = !out_valid_q || out_ready;
    assign w_in_xfer  = !rst && w_can_load && w_found;
    assign w_out_xfer = out_valid_q && out_ready;

    // Walk the ring starting one past the last grant; first valid index wins.
    always_comb begin : p_search
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = last_grant_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (w_idx == c_LAST_IDX) ? '0 : w_idx + ID_WIDTH'(1);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin : p_word_mux
        w_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == ID_WIDTH'(i)) begin
                w_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
            assign req_ready[g] = w_in_xfer && (w_sel == ID_WIDTH'(g));
        end
    endgenerate

    always_comb begin : p_next
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        last_grant_d = last_grant_q;
        if (w_in_xfer) begin
            out_valid_d  = 1'b1;
            out_data_d   = ~w_word;
            out_id_d     = w_sel;
            last_grant_d = w_sel;
        end else if (w_out_xfer) begin
            out_valid_d  = 1'b0;
        end
    end

    // Reset leaves the pointer on the last index so the first search starts at 0.
    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            last_grant_q <= c_LAST_IDX;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule
`default_nettype wire

// File: tb/tb_inverter_arbiter.sv
`default_nettype none
// Directed and random checks of inverter_arbiter against a queue-based model.
module tb_inverter_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic [IW-1:0]    out_id;
    logic             out_ready;
    logic [DW-1:0]    words [NR];

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    typedef struct {
        logic [DW-1:0] d;
        int            id;
    } item_t;

    item_t         q[$];
    int            m_last   = NR - 1;
    logic [DW-1:0] m_hold_d = '0;
    int            m_hold_id = 0;
    int            exp_sel;
    logic [NR-1:0] exp_ready;

    assign req_data = {words[3], words[2], words[1], words[0]};

    inverter_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .ID_WIDTH  (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_id   (out_id),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: at most one word in flight; grant = first valid index after the last grant.
    always @(negedge clk) begin
        if (checking) begin
            exp_sel   = -1;
            exp_ready = '0;
            if (!rst && !(q.size() != 0 && !out_ready)) begin
                for (int k = 1; k <= NR; k++) begin
                    if (exp_sel < 0 && req_valid[(m_last + k) % NR]) exp_sel = (m_last + k) % NR;
                end
            end
            if (exp_sel >= 0) exp_ready[exp_sel] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("out_data", 64'(out_data), 64'((q.size() != 0) ? q[0].d : m_hold_d));
            chk("out_id", 64'(out_id), 64'((q.size() != 0) ? q[0].id : m_hold_id));
            if (rst) begin
                q.delete();
                m_last    = NR - 1;
                m_hold_d  = '0;
                m_hold_id = 0;
            end else begin
                if (q.size() != 0 && out_ready) begin
                    m_hold_d  = q[0].d;
                    m_hold_id = q[0].id;
                    void'(q.pop_front());
                end
                if (exp_sel >= 0) begin
                    q.push_back('{d: ~words[exp_sel], id: exp_sel});
                    m_last = exp_sel;
                end
            end
        end
    end

    task automatic apply(input logic r, input logic [NR-1:0] v, input logic o);
        rst       = r;
        req_valid = v;
        out_ready = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'h00; words[3] = 8'h00;
        apply(1'b1, 4'b0000, 1'b0);
        tick();
        checking = 1'b1;

        // Reset state; requests during reset are never accepted.
        apply(1'b1, 4'b1111, 1'b1);
        at_neg();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data", 64'(out_data), 64'h0);
        chk("rst_id", 64'(out_id), 64'h0);
        tick();

        // Single request, one-cycle latency.
        words[0] = 8'h5A;
        apply(1'b0, 4'b0001, 1'b1);
        at_neg();
        chk("single_ready", 64'(req_ready), 64'b0001);
        tick();
        apply(1'b0, 4'b0000, 1'b1);
        at_neg();
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_data", 64'(out_data), 64'hA5);
        chk("single_id", 64'(out_id), 64'h0);
        chk("idle_ready", 64'(req_ready), 64'h0);
        tick();

        // Fresh reset, then all four requesters continuously valid.
        apply(1'b1, 4'b0000, 1'b1);
        tick();
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h0F; words[3] = 8'hF0;
        apply(1'b0, 4'b1111, 1'b1);
        for (int n = 0; n < 5; n++) begin
            logic [DW-1:0] rr_exp [NR];
            rr_exp[0] = 8'hFF; rr_exp[1] = 8'h00; rr_exp[2] = 8'hF0; rr_exp[3] = 8'h0F;
            tick();
            at_neg();
            chk("rr_id", 64'(out_id), 64'(n % NR));
            chk("rr_data", 64'(out_data), 64'(rr_exp[n % NR]));
        end

        // Backpressure: result held, nothing accepted, pointer frozen.
        tick();
        apply(1'b0, 4'b1111, 1'b0);
        for (int n = 0; n < 3; n++) begin
            at_neg();
            chk("hold_ready", 64'(req_ready), 64'h0);
            chk("hold_id", 64'(out_id), 64'h1);
            chk("hold_data", 64'(out_data), 64'h00);
            tick();
        end
        apply(1'b0, 4'b1111, 1'b1);
        at_neg();
        chk("release_ready", 64'(req_ready), 64'b0100);
        tick();
        at_neg();
        chk("release_id", 64'(out_id), 64'h2);

        // Wrap-around search from last_grant=3.
        tick();
        apply(1'b0, 4'b1000, 1'b1);
        at_neg();
        chk("to3_ready", 64'(req_ready), 64'b1000);
        tick();
        apply(1'b0, 4'b0100, 1'b1);
        at_neg();
        chk("wrap2_ready", 64'(req_ready), 64'b0100);
        tick();
        apply(1'b0, 4'b0110, 1'b1);
        at_neg();
        chk("wrap1_ready", 64'(req_ready), 64'b0010);
        tick();
        at_neg();
        chk("wrap1_id", 64'(out_id), 64'h1);
        chk("wrap1_data", 64'(out_data), 64'h00);

        // Reset discards a stalled result.
        tick();
        apply(1'b0, 4'b1111, 1'b1);
        tick();
        apply(1'b0, 4'b1111, 1'b0);
        tick();
        apply(1'b1, 4'b1111, 1'b0);
        at_neg();
        chk("rstfl_ready", 64'(req_ready), 64'h0);
        chk("rstfl_pre_valid", 64'(out_valid), 64'h1);
        tick();
        apply(1'b0, 4'b0110, 1'b1);
        at_neg();
        chk("rstfl_valid", 64'(out_valid), 64'h0);
        chk("rstfl_data", 64'(out_data), 64'h0);
        chk("rstfl_id", 64'(out_id), 64'h0);
        chk("rstfl_ready_after", 64'(req_ready), 64'b0010);
        tick();
        at_neg();
        chk("rstfl_first_id", 64'(out_id), 64'h1);
        tick();

        // Random stress against the model.
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < NR; i++) words[i] = DW'($urandom_range(0, 255));
            apply(1'b0, NR'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            tick();
        end
        apply(1'b0, 4'b0000, 1'b1);
        tick();
        tick();
        tick();
        at_neg();
        chk("drained", 64'(q.size()), 64'h0);
        chk("drained_valid", 64'(out_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
